// File: rtl/cp0_excp_unit_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, constant register values
// and the Status field layout.
package cp0_excp_unit_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [31:0] PRID_VALUE   = 32'h0000_4842;
    localparam logic [31:0] CONFIG_VALUE = 32'h0000_8000;
    localparam logic [3:0]  STATUS_CU    = 4'b0001;

    typedef struct packed {
        logic [7:0] im;
        logic       exl;
        logic       ie;
    } status_t;

    function automatic logic loads_badvaddr(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare register and the sticky timer
// interrupt that is cleared by any write to Compare.
module cp0_timer #(
    parameter int COUNT_DIV_LOG2 = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_intr_o
);
    localparam int PW = (COUNT_DIV_LOG2 > 0) ? COUNT_DIV_LOG2 : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d, count_inc;
    logic [31:0]   compare_q, compare_d;
    logic          timer_q, timer_d;
    logic          tick;

    always_comb begin
        tick      = (COUNT_DIV_LOG2 == 0) ? 1'b1 : (presc_q == '1);
        count_inc = count_q + 32'd1;

        presc_d = presc_q + PW'(1);
        if (count_we_i || (COUNT_DIV_LOG2 == 0)) presc_d = '0;

        count_d = count_q;
        if (count_we_i)  count_d = wdata_i;
        else if (tick)   count_d = count_inc;

        compare_d = compare_we_i ? wdata_i : compare_q;

        // A Compare write clears the interrupt even if the match happens the same cycle
        timer_d = timer_q;
        if (!count_we_i && tick && (count_inc == compare_q)) timer_d = 1'b1;
        if (compare_we_i) timer_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            timer_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            timer_q   <= timer_d;
        end
    end

    assign count_o      = count_q;
    assign compare_o    = compare_q;
    assign timer_intr_o = timer_q;

endmodule

// File: rtl/cp0_excp_unit.sv
// CP0 exception unit: MTC0/MFC0 register file, exception/ERET state update,
// interrupt request generation and the one-cycle pipeline flush/redirect.
module cp0_excp_unit
    import cp0_excp_unit_pkg::*;
#(
    parameter int          HW_INTR_NUM    = 6,
    parameter int          COUNT_DIV_LOG2 = 0,
    parameter logic [31:0] EXCP_VEC       = 32'h0000_0020
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we_i,
    input  logic [4:0]             waddr_i,
    input  logic [31:0]            wdata_i,
    input  logic [4:0]             raddr_i,
    output logic [31:0]            rdata_o,
    input  logic [HW_INTR_NUM-1:0] intr_i,
    input  logic                   excp_valid_i,
    input  logic [4:0]             excp_code_i,
    input  logic [31:0]            excp_pc_i,
    input  logic                   excp_in_delay_i,
    input  logic [31:0]            excp_badvaddr_i,
    input  logic                   eret_i,
    output logic                   flush_o,
    output logic [31:0]            new_pc_o,
    output logic                   intr_req_o,
    output logic [31:0]            status_o,
    output logic [31:0]            cause_o,
    output logic [31:0]            epc_o,
    output logic                   timer_intr_o
);
    status_t     status_q, status_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  ip_hw_q, intr_ext;
    logic [4:0]  exc_code_q, exc_code_d;
    logic        bd_q, bd_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badv_q, badv_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [31:0] count, compare;
    logic [7:0]  ip;
    logic        timer_intr;
    logic        wr_status, wr_cause, wr_epc;

    assign wr_status = we_i && (waddr_i == CP0_STATUS);
    assign wr_cause  = we_i && (waddr_i == CP0_CAUSE);
    assign wr_epc    = we_i && (waddr_i == CP0_EPC);

    cp0_timer #(
        .COUNT_DIV_LOG2 (COUNT_DIV_LOG2)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .count_we_i   (we_i && (waddr_i == CP0_COUNT)),
        .compare_we_i (we_i && (waddr_i == CP0_COMPARE)),
        .wdata_i      (wdata_i),
        .count_o      (count),
        .compare_o    (compare),
        .timer_intr_o (timer_intr)
    );

    always_comb begin
        intr_ext = '0;
        intr_ext[HW_INTR_NUM-1:0] = intr_i;

        // Later assignments win: exception over ERET over MTC0
        status_d = status_q;
        if (wr_status) begin
            status_d.im  = wdata_i[15:8];
            status_d.exl = wdata_i[1];
            status_d.ie  = wdata_i[0];
        end
        if (eret_i)       status_d.exl = 1'b0;
        if (excp_valid_i) status_d.exl = 1'b1;

        ip_sw_d    = wr_cause ? wdata_i[9:8] : ip_sw_q;
        exc_code_d = excp_valid_i ? excp_code_i : exc_code_q;

        bd_d  = bd_q;
        epc_d = wr_epc ? wdata_i : epc_q;
        if (excp_valid_i) begin
            epc_d = epc_q;
            if (!status_q.exl) begin
                bd_d  = excp_in_delay_i;
                epc_d = excp_in_delay_i ? (excp_pc_i - 32'd4) : excp_pc_i;
            end
        end

        badv_d = (excp_valid_i && loads_badvaddr(excp_code_i)) ? excp_badvaddr_i : badv_q;

        flush_d  = excp_valid_i || eret_i;
        new_pc_d = '0;
        if (excp_valid_i)  new_pc_d = EXCP_VEC;
        else if (eret_i)   new_pc_d = epc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q   <= '0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            exc_code_q <= '0;
            bd_q       <= 1'b0;
            epc_q      <= '0;
            badv_q     <= '0;
            flush_q    <= 1'b0;
            new_pc_q   <= '0;
        end else begin
            status_q   <= status_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= intr_ext;
            exc_code_q <= exc_code_d;
            bd_q       <= bd_d;
            epc_q      <= epc_d;
            badv_q     <= badv_d;
            flush_q    <= flush_d;
            new_pc_q   <= new_pc_d;
        end
    end

    assign ip       = {ip_hw_q[5] | timer_intr, ip_hw_q[4:0], ip_sw_q};
    assign status_o = {STATUS_CU, 12'h000, status_q.im, 6'h00, status_q.exl, status_q.ie};
    assign cause_o  = {bd_q, timer_intr, 14'h0000, ip, 1'b0, exc_code_q, 2'b00};
    assign epc_o    = epc_q;
    assign flush_o  = flush_q;
    assign new_pc_o = new_pc_q;
    assign timer_intr_o = timer_intr;
    assign intr_req_o   = (|(ip & status_q.im)) && status_q.ie && !status_q.exl;

    always_comb begin
        case (raddr_i)
            CP0_BADVADDR: rdata_o = badv_q;
            CP0_COUNT:    rdata_o = count;
            CP0_COMPARE:  rdata_o = compare;
            CP0_STATUS:   rdata_o = status_o;
            CP0_CAUSE:    rdata_o = cause_o;
            CP0_EPC:      rdata_o = epc_q;
            CP0_PRID:     rdata_o = PRID_VALUE;
            CP0_CONFIG:   rdata_o = CONFIG_VALUE;
            default:      rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_excp_unit.sv
// Directed self-checking bench for cp0_excp_unit (Count prescaled by 4).
module tb_cp0_excp_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  intr_i;
    logic        excp_valid_i;
    logic [4:0]  excp_code_i;
    logic [31:0] excp_pc_i;
    logic        excp_in_delay_i;
    logic [31:0] excp_badvaddr_i;
    logic        eret_i;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        intr_req_o;
    logic [31:0] status_o, cause_o, epc_o;
    logic        timer_intr_o;

    int n_checks = 0;
    int n_fail   = 0;

    cp0_excp_unit #(
        .HW_INTR_NUM    (6),
        .COUNT_DIV_LOG2 (2),
        .EXCP_VEC       (32'h0000_0020)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .we_i            (we_i),
        .waddr_i         (waddr_i),
        .wdata_i         (wdata_i),
        .raddr_i         (raddr_i),
        .rdata_o         (rdata_o),
        .intr_i          (intr_i),
        .excp_valid_i    (excp_valid_i),
        .excp_code_i     (excp_code_i),
        .excp_pc_i       (excp_pc_i),
        .excp_in_delay_i (excp_in_delay_i),
        .excp_badvaddr_i (excp_badvaddr_i),
        .eret_i          (eret_i),
        .flush_o         (flush_o),
        .new_pc_o        (new_pc_o),
        .intr_req_o      (intr_req_o),
        .status_o        (status_o),
        .cause_o         (cause_o),
        .epc_o           (epc_o),
        .timer_intr_o    (timer_intr_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        step();
        we_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        excp_valid_i = 1'b1; excp_code_i = 5'd4; excp_pc_i = 32'h40;
        excp_badvaddr_i = 32'h55; eret_i = 1'b1;
        repeat (3) step();
        n_checks++; if (status_o !== 32'h1000_0000) begin n_fail++; $display("FAIL reset_status got %h exp %h", status_o, 32'h1000_0000); end
        n_checks++; if (cause_o !== 32'h0) begin n_fail++; $display("FAIL reset_cause got %h exp 0", cause_o); end
        n_checks++; if (epc_o !== 32'h0) begin n_fail++; $display("FAIL reset_epc got %h exp 0", epc_o); end
        n_checks++; if (flush_o !== 1'b0 || new_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_flush got %b/%h exp 0/0", flush_o, new_pc_o); end
        n_checks++; if (timer_intr_o !== 1'b0) begin n_fail++; $display("FAIL reset_timer got %b exp 0", timer_intr_o); end
        raddr_i = 5'd15; #1;
        n_checks++; if (rdata_o !== 32'h0000_4842) begin n_fail++; $display("FAIL prid got %h exp %h", rdata_o, 32'h0000_4842); end
        raddr_i = 5'd16; #1;
        n_checks++; if (rdata_o !== 32'h0000_8000) begin n_fail++; $display("FAIL config got %h exp %h", rdata_o, 32'h0000_8000); end
        raddr_i = 5'd8; #1;
        n_checks++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_badvaddr got %h exp 0", rdata_o); end
        excp_valid_i = 1'b0; eret_i = 1'b0; excp_code_i = '0; excp_pc_i = '0; excp_badvaddr_i = '0;
    endtask

    task automatic test_timer();
        rst_n = 1'b1; raddr_i = 5'd9;
        mtc0(5'd11, 32'd10);
        n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL no_flush_after_reset got %b exp 0", flush_o); end
        n_checks++; if (rdata_o !== 32'd0) begin n_fail++; $display("FAIL count_first got %0d exp 0", rdata_o); end
        repeat (38) step();
        n_checks++; if (rdata_o !== 32'd9 || timer_intr_o !== 1'b0) begin n_fail++; $display("FAIL timer_before got cnt %0d ti %b exp 9/0", rdata_o, timer_intr_o); end
        step();
        n_checks++; if (rdata_o !== 32'd10 || timer_intr_o !== 1'b1) begin n_fail++; $display("FAIL timer_rise got cnt %0d ti %b exp 10/1", rdata_o, timer_intr_o); end
        n_checks++; if (cause_o !== 32'h4000_8000) begin n_fail++; $display("FAIL cause_ti got %h exp %h", cause_o, 32'h4000_8000); end
        repeat (5) step();
        n_checks++; if (timer_intr_o !== 1'b1) begin n_fail++; $display("FAIL timer_hold got %b exp 1", timer_intr_o); end
        mtc0(5'd11, 32'd1000);
        raddr_i = 5'd11; #1;
        n_checks++; if (timer_intr_o !== 1'b0 || rdata_o !== 32'd1000) begin n_fail++; $display("FAIL timer_clear got ti %b cmp %0d exp 0/1000", timer_intr_o, rdata_o); end
    endtask

    task automatic test_count_wrap();
        raddr_i = 5'd9;
        mtc0(5'd9, 32'hFFFF_FFFF);
        repeat (3) step();
        n_checks++; if (rdata_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL count_load got %h exp ffffffff", rdata_o); end
        step();
        n_checks++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL count_wrap got %h exp 0", rdata_o); end
    endtask

    task automatic test_exception();
        excp_valid_i = 1'b1; excp_code_i = 5'd4; excp_pc_i = 32'h100;
        excp_in_delay_i = 1'b1; excp_badvaddr_i = 32'h123; raddr_i = 5'd8;
        step();
        excp_valid_i = 1'b0; excp_in_delay_i = 1'b0;
        n_checks++; if (flush_o !== 1'b1 || new_pc_o !== 32'h20) begin n_fail++; $display("FAIL excp_flush got %b/%h exp 1/20", flush_o, new_pc_o); end
        n_checks++; if (epc_o !== 32'hFC) begin n_fail++; $display("FAIL excp_epc got %h exp fc", epc_o); end
        n_checks++; if (cause_o !== 32'h8000_0010) begin n_fail++; $display("FAIL excp_cause got %h exp 80000010", cause_o); end
        n_checks++; if (status_o !== 32'h1000_0002) begin n_fail++; $display("FAIL excp_status got %h exp 10000002", status_o); end
        n_checks++; if (rdata_o !== 32'h123) begin n_fail++; $display("FAIL excp_badvaddr got %h exp 123", rdata_o); end
        step();
        n_checks++; if (flush_o !== 1'b0 || new_pc_o !== 32'h0) begin n_fail++; $display("FAIL excp_flush_end got %b/%h exp 0/0", flush_o, new_pc_o); end
    endtask

    task automatic test_nested();
        excp_valid_i = 1'b1; excp_code_i = 5'd12; excp_pc_i = 32'h200; excp_badvaddr_i = 32'h999;
        step();
        excp_valid_i = 1'b0;
        n_checks++; if (flush_o !== 1'b1 || new_pc_o !== 32'h20) begin n_fail++; $display("FAIL nest_flush got %b/%h exp 1/20", flush_o, new_pc_o); end
        n_checks++; if (epc_o !== 32'hFC) begin n_fail++; $display("FAIL nest_epc got %h exp fc", epc_o); end
        n_checks++; if (cause_o !== 32'h8000_0030) begin n_fail++; $display("FAIL nest_cause got %h exp 80000030", cause_o); end
        n_checks++; if (rdata_o !== 32'h123) begin n_fail++; $display("FAIL nest_badvaddr got %h exp 123", rdata_o); end
        step();
    endtask

    task automatic test_eret();
        raddr_i = 5'd14;
        we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h400; #1;
        n_checks++; if (rdata_o !== 32'hFC) begin n_fail++; $display("FAIL rd_no_bypass got %h exp fc", rdata_o); end
        step();
        we_i = 1'b0;
        n_checks++; if (epc_o !== 32'h400) begin n_fail++; $display("FAIL epc_write got %h exp 400", epc_o); end
        eret_i = 1'b1;
        step();
        eret_i = 1'b0;
        n_checks++; if (flush_o !== 1'b1 || new_pc_o !== 32'h400) begin n_fail++; $display("FAIL eret_flush got %b/%h exp 1/400", flush_o, new_pc_o); end
        n_checks++; if (status_o !== 32'h1000_0000) begin n_fail++; $display("FAIL eret_status got %h exp 10000000", status_o); end
        step();
        n_checks++; if (flush_o !== 1'b0 || new_pc_o !== 32'h0) begin n_fail++; $display("FAIL eret_flush_end got %b/%h exp 0/0", flush_o, new_pc_o); end
    endtask

    task automatic test_interrupts();
        mtc0(5'd12, 32'h0000_0401);
        intr_i = 6'b000001; #1;
        n_checks++; if (intr_req_o !== 1'b0) begin n_fail++; $display("FAIL intr_latency got %b exp 0", intr_req_o); end
        step();
        n_checks++; if (intr_req_o !== 1'b1) begin n_fail++; $display("FAIL intr_req got %b exp 1", intr_req_o); end
        n_checks++; if (cause_o !== 32'h8000_0430) begin n_fail++; $display("FAIL intr_cause got %h exp 80000430", cause_o); end
        mtc0(5'd12, 32'h0000_0403);
        n_checks++; if (intr_req_o !== 1'b0) begin n_fail++; $display("FAIL intr_exl_mask got %b exp 0", intr_req_o); end
        intr_i = '0;
        mtc0(5'd12, 32'h0000_0101);
        mtc0(5'd13, 32'hFFFF_FFFF);
        n_checks++; if (cause_o !== 32'h8000_0330) begin n_fail++; $display("FAIL cause_wmask got %h exp 80000330", cause_o); end
        n_checks++; if (intr_req_o !== 1'b1) begin n_fail++; $display("FAIL sw_intr got %b exp 1", intr_req_o); end
        mtc0(5'd12, 32'hFFFF_FFFF);
        n_checks++; if (status_o !== 32'h1000_FF03) begin n_fail++; $display("FAIL status_wmask got %h exp 1000ff03", status_o); end
        mtc0(5'd13, 32'h0);
        mtc0(5'd12, 32'h0);
    endtask

    task automatic test_priority();
        excp_valid_i = 1'b1; excp_code_i = 5'd0; excp_pc_i = 32'h300; excp_in_delay_i = 1'b0;
        eret_i = 1'b1; we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h0000_0001;
        step();
        excp_valid_i = 1'b0; eret_i = 1'b0; we_i = 1'b0;
        n_checks++; if (status_o !== 32'h1000_0003) begin n_fail++; $display("FAIL prio_status got %h exp 10000003", status_o); end
        n_checks++; if (flush_o !== 1'b1 || new_pc_o !== 32'h20) begin n_fail++; $display("FAIL prio_flush got %b/%h exp 1/20", flush_o, new_pc_o); end
        n_checks++; if (epc_o !== 32'h300 || cause_o !== 32'h0) begin n_fail++; $display("FAIL prio_epc_cause got %h/%h exp 300/0", epc_o, cause_o); end
        raddr_i = 5'd3; #1;
        n_checks++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got %h exp 0", rdata_o); end
    endtask

    initial begin
        we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0; intr_i = '0;
        excp_in_delay_i = 1'b0;
        test_reset();
        test_timer();
        test_count_wrap();
        test_exception();
        test_nested();
        test_eret();
        test_interrupts();
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
